// File: rtl/adc_capture.sv
// LTC6912 pre-amp programming at power-up, then one 34-SCK LTC1407A frame per
// clockenable request; channel 0/1 are delivered as 12-bit offset-binary words.
module adc_capture #(
  parameter int          CLK_DIV = 2,
  parameter logic [7:0]  GAIN    = 8'h11
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clockenable,
  input  logic        spi_miso,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        amp_cs,
  output logic        amp_shdn,
  output logic        ad_conv,
  output logic [11:0] datos,
  output logic [11:0] datos_b,
  output logic        datos_valid,
  output logic [5:0]  bloque,
  output logic        busy
);

  typedef enum logic [2:0] {
    AMP_LOAD,
    IDLE,
    CONV,
    SHIFT,
    DONE
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             half;      // 0 = low half of the SCK period, 1 = high half
  logic [2:0]       amp_bit;
  logic [13:0]      raw0;
  logic [13:0]      raw1;

  assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign amp_shdn = 1'b0;

  // NOTE: every register here is assigned with <= so all state updates use
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the raw shift registers are cleared too; they only feed datos at
      // DONE, but clearing keeps an aborted frame from leaking stale bits.
      state       <= AMP_LOAD;
      div_cnt     <= '0;
      half        <= 1'b0;
      amp_bit     <= '0;
      raw0        <= '0;
      raw1        <= '0;
      spi_sck     <= 1'b0;
      spi_mosi    <= 1'b0;
      amp_cs      <= 1'b1;
      ad_conv     <= 1'b0;
      datos       <= 12'h800;
      datos_b     <= 12'h800;
      datos_valid <= 1'b0;
      bloque      <= '0;
      busy        <= 1'b1;
    end else begin
      datos_valid <= 1'b0;
      case (state)
        AMP_LOAD: begin
          // amp_cs still high marks the first cycle out of reset: open the
          // transfer with bit 7 and start the divider from zero.
          if (amp_cs) begin
            amp_cs   <= 1'b0;
            spi_mosi <= GAIN[7];
            div_cnt  <= '0;
            half     <= 1'b0;
          end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
              half    <= ~half;
              spi_sck <= ~half;
              if (half) begin
                if (amp_bit == 3'd7) begin
                  state    <= IDLE;
                  amp_cs   <= 1'b1;
                  spi_mosi <= 1'b0;
                  amp_bit  <= '0;
                  busy     <= 1'b0;
                end else begin
                  amp_bit  <= amp_bit + 1'b1;
                  spi_mosi <= GAIN[3'd6 - amp_bit];
                end
              end
            end
          end
        end

        IDLE: begin
          div_cnt <= '0;
          half    <= 1'b0;
          spi_sck <= 1'b0;
          if (clockenable) begin
            state   <= CONV;
            ad_conv <= 1'b1;
            busy    <= 1'b1;
          end
        end

        CONV: begin
          // ad_conv spans one full (silent) SCK period.
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            half <= ~half;
            if (half) begin
              state   <= SHIFT;
              ad_conv <= 1'b0;
              bloque  <= '0;
            end
          end
        end

        SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            half    <= ~half;
            spi_sck <= ~half;
            if (!half) begin
              if (bloque >= 6'd2 && bloque <= 6'd15)
                raw0 <= {raw0[12:0], spi_miso};
              else if (bloque >= 6'd18 && bloque <= 6'd31)
                raw1 <= {raw1[12:0], spi_miso};
            end else if (bloque == 6'd33) begin
              state       <= DONE;
              bloque      <= '0;
              datos       <= {~raw0[13], raw0[12:2]};
              datos_b     <= {~raw1[13], raw1[12:2]};
              datos_valid <= 1'b1;
            end else begin
              bloque <= bloque + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= AMP_LOAD;
          amp_cs <= 1'b1;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
